fetch_unit: RTL and testbench

Instruction-fetch stage between the PC register and the IF/ID decode boundary. Takes the current PC value and issues one request at a time to instruction memory over a req/ack handshake. Returns each fetched word with its PC through a small in-order queue to the decode stage, and drives the PC's enable input so the PC advances only when a fetch completes or a redirect occurs. Handles flush (branch/jump redirect) by discarding queued and in-flight instructions.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch between the PC register and the IF/ID boundary; optional stats via FETCH_STAT_EN.
// Latency: request visible 1 cycle after issue; an acked word reaches the queue head 1 cycle after ack.
// Backpressure: id_ready_i low fills the FQ_DEPTH-entry queue; a full queue blocks new issues, never an ack.
module fetch_unit #(
  parameter int FQ_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  output logic        pc_enable_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
`ifdef FETCH_STAT_EN
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] drop_cnt_o,
`endif
  input  logic        id_ready_i
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   dat_q [FQ_DEPTH];
  logic [31:0]   pcq_q [FQ_DEPTH];
  logic          push, pop;

  // Next-state logic: issue from IDLE, hold the request until ack, divert to DROP on flush.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i && (count_q < DEPTH_C)) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_i;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
          push    = !flush_i;
        end else if (flush_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // PC advances with each accepted word, or loads the redirect target on flush.
  assign pc_enable_o = ((state_q == REQ) && imem_ack_i) || flush_i;
  assign pop         = (count_q != '0) && id_ready_i && !flush_i;

  // State and request registers; reset drops any outstanding request at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // Queue pointers and occupancy; flush empties the queue on the next edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue storage: each entry holds the fetched word and the address it came from.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        dat_q[i] <= '0;
        pcq_q[i] <= '0;
      end
    end else if (push) begin
      dat_q[wr_ptr_q] <= imem_data_i;
      pcq_q[wr_ptr_q] <= addr_q;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = dat_q[rd_ptr_q];
  assign inst_pc_o    = pcq_q[rd_ptr_q];

`ifdef FETCH_STAT_EN
  logic        drop_evt;
  logic [31:0] fetch_cnt_q, drop_cnt_q;

  // A response is discarded when it lands in DROP or coincides with a flush in REQ.
  assign drop_evt = imem_ack_i && ((state_q == DROP) || ((state_q == REQ) && flush_i));

  // Free-running statistics counters, wrapping at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (push)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (drop_evt) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle table plus a scoreboarded random stream for fetch_unit.
// Inputs are driven 1 time unit after the rising edge and outputs sampled 1 unit later.
// The bench's memory model acks after a bounded latency; all expectations come from bench state.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk;
  logic        rst, start, flush, ack, id_ready;
  logic [31:0] pc, data;
  logic        pc_en, req, valid;
  logic [31:0] addr, inst, inst_pc;
`ifdef FETCH_STAT_EN
  logic [31:0] fetch_cnt, drop_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  fetch_unit #(.FQ_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .pc_i         (pc),
    .pc_enable_o  (pc_en),
    .flush_i      (flush),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ack_i   (ack),
    .imem_data_i  (data),
    .inst_valid_o (valid),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
`ifdef FETCH_STAT_EN
    .fetch_cnt_o  (fetch_cnt),
    .drop_cnt_o   (drop_cnt),
`endif
    .id_ready_i   (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          st, fl, ak, rd;
    logic [31:0] pc;
    bit          rq;
    logic [31:0] ad;
    bit          pe, vl;
    logic [31:0] ip;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  vec_t tbl [21];
  ent_t sb [$];
  ent_t ent;

  // stream model state
  bit          req_m, drop_m, fl, rd, ak, push_e;
  logic [31:0] addr_m, pc_m;
  int          lat_m, cnt0, req_hi, fetch_m, dropc_m;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mkv(input bit st, fl, ak, rd, input logic [31:0] pcv,
                               input bit rq, input logic [31:0] ad, input bit pe, vl,
                               input logic [31:0] ip);
    vec_t v;
    v.st = st; v.fl = fl; v.ak = ak; v.rd = rd; v.pc = pcv;
    v.rq = rq; v.ad = ad; v.pe = pe; v.vl = vl; v.ip = ip;
    return v;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           st fl ak rd  pc          req addr        pce vld inst_pc
    tbl[0]  = mkv(H, L, L, H, 32'h00, L, 32'h00, L, L, 32'h00);
    tbl[1]  = mkv(H, L, H, H, 32'h00, H, 32'h00, H, L, 32'h00);
    tbl[2]  = mkv(H, L, L, H, 32'h04, L, 32'h00, L, H, 32'h00);
    tbl[3]  = mkv(H, L, H, H, 32'h04, H, 32'h04, H, L, 32'h00);
    tbl[4]  = mkv(H, L, L, H, 32'h08, L, 32'h04, L, H, 32'h04);
    tbl[5]  = mkv(H, L, H, H, 32'h08, H, 32'h08, H, L, 32'h00);
    tbl[6]  = mkv(L, L, L, H, 32'h0C, L, 32'h08, L, H, 32'h08);
    tbl[7]  = mkv(H, L, L, H, 32'h10, L, 32'h08, L, L, 32'h00);
    tbl[8]  = mkv(H, H, L, H, 32'h10, H, 32'h10, H, L, 32'h00);  // flush in REQ
    tbl[9]  = mkv(H, L, L, H, 32'h40, H, 32'h10, L, L, 32'h00);
    tbl[10] = mkv(H, L, L, H, 32'h40, H, 32'h10, L, L, 32'h00);
    tbl[11] = mkv(H, L, H, H, 32'h40, H, 32'h10, L, L, 32'h00);  // ack in DROP
    tbl[12] = mkv(H, L, L, L, 32'h40, L, 32'h10, L, L, 32'h00);
    tbl[13] = mkv(H, L, H, L, 32'h40, H, 32'h40, H, L, 32'h00);
    tbl[14] = mkv(H, L, L, L, 32'h44, L, 32'h40, L, H, 32'h40);
    tbl[15] = mkv(H, L, H, L, 32'h44, H, 32'h44, H, H, 32'h40);
    tbl[16] = mkv(H, L, L, L, 32'h48, L, 32'h44, L, H, 32'h40);
    tbl[17] = mkv(H, H, H, L, 32'h48, H, 32'h48, H, H, 32'h40);  // flush with ack, 2 queued
    tbl[18] = mkv(L, L, L, L, 32'h80, L, 32'h48, L, L, 32'h00);
    tbl[19] = mkv(L, L, H, H, 32'h80, L, 32'h48, L, L, 32'h00);  // spurious ack in IDLE
    tbl[20] = mkv(L, L, L, H, 32'h80, L, 32'h48, L, L, 32'h00);

    rst = 1'b1; start = 1'b0; flush = 1'b0; ack = 1'b0; id_ready = 1'b0;
    pc = '0; data = '0;
    tick(); tick(); #1;

    // reset values
    check1 ("rst_req",   req,     1'b0);
    check32("rst_addr",  addr,    32'h0);
    check1 ("rst_valid", valid,   1'b0);
    check32("rst_inst",  inst,    32'h0);
    check32("rst_ipc",   inst_pc, 32'h0);
    check1 ("rst_pcen",  pc_en,   1'b0);
`ifdef FETCH_STAT_EN
    check32("rst_fcnt",  fetch_cnt, 32'h0);
    check32("rst_dcnt",  drop_cnt,  32'h0);
`endif

    // directed cycle table
    tick();
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      start = tbl[i].st; flush = tbl[i].fl; ack = tbl[i].ak; id_ready = tbl[i].rd;
      pc = tbl[i].pc; data = dfun(tbl[i].ad);
      #1;
      check1 ($sformatf("t%0d_req", i),   req,   tbl[i].rq);
      check32($sformatf("t%0d_addr", i),  addr,  tbl[i].ad);
      check1 ($sformatf("t%0d_pcen", i),  pc_en, tbl[i].pe);
      check1 ($sformatf("t%0d_valid", i), valid, tbl[i].vl);
      if (tbl[i].vl) begin
        check32($sformatf("t%0d_ipc", i),  inst_pc, tbl[i].ip);
        check32($sformatf("t%0d_inst", i), inst,    dfun(tbl[i].ip));
      end
      tick();
    end
`ifdef FETCH_STAT_EN
    check32("t_fetch_cnt", fetch_cnt, 32'd5);
    check32("t_drop_cnt",  drop_cnt,  32'd2);
`endif

    // reset pulsed while a request is outstanding
    start = 1'b1; flush = 1'b0; ack = 1'b0; id_ready = 1'b1; pc = 32'h200;
    #1;
    check1("r_idle_req", req, 1'b0);
    tick();
    start = 1'b0;
    #1;
    check1 ("r_req_up",  req,  1'b1);
    check32("r_addr",    addr, 32'h200);
    rst = 1'b1;
    #1;
    check1("r_async_req", req,   1'b0);
    check1("r_async_vld", valid, 1'b0);
    tick();
    rst = 1'b0; ack = 1'b1; data = dfun(32'h200);
    #1;
    check1("r_late_ack_pcen", pc_en, 1'b0);
    tick();
    ack = 1'b0;
    #1;
    check1("r_late_ack_vld", valid, 1'b0);
    check1("r_late_ack_req", req,   1'b0);
`ifdef FETCH_STAT_EN
    check32("r_fetch_cnt", fetch_cnt, 32'd0);
`endif

    // scoreboarded stream: fill with decode stalled, release once, then random traffic
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    req_m = 1'b0; drop_m = 1'b0; addr_m = '0; pc_m = 32'h100; lat_m = 0;
    req_hi = 0; fetch_m = 0; dropc_m = 0;
    sb.delete();
    for (int cyc = 0; cyc < 360; cyc++) begin
      if (cyc < 20) begin
        rd = 1'b0; fl = 1'b0;
      end else if (cyc == 20) begin
        rd = 1'b1; fl = 1'b0;
      end else begin
        rd = ($urandom_range(0, 2) != 0);
        fl = ($urandom_range(0, 11) == 0);
      end
      ak = req_m && (lat_m == 0);
      start = 1'b1; pc = pc_m; flush = fl; id_ready = rd; ack = ak;
      data = ak ? dfun(addr_m) : $urandom;
      #1;
      check1("s_req", req, req_m);
      if (req_m) check32("s_addr", addr, addr_m);
      check1("s_valid", valid, sb.size() != 0);
      check1("s_pcen", pc_en, fl | (ak & ~drop_m));
      if (cyc < 20 && req) req_hi++;

      cnt0   = sb.size();
      push_e = ak && !drop_m && !fl;
      if (cnt0 != 0 && rd && !fl) begin
        check32("s_ipc",  inst_pc, sb[0].pc);
        check32("s_inst", inst,    sb[0].inst);
        void'(sb.pop_front());
      end
      if (fl) sb.delete();
      else if (push_e) begin
        ent.pc = addr_m; ent.inst = dfun(addr_m);
        sb.push_back(ent);
        fetch_m++;
      end
      if (ak && (drop_m || fl)) dropc_m++;

      if (req_m) begin
        if (ak) begin
          req_m = 1'b0; drop_m = 1'b0;
        end else begin
          if (fl) drop_m = 1'b1;
          if (lat_m > 0) lat_m--;
        end
      end else if (!fl && cnt0 < DEPTH) begin
        req_m = 1'b1; addr_m = pc_m;
        lat_m = (cyc < 20) ? 0 : int'($urandom_range(0, 3));
      end
      if (fl) pc_m = $urandom & 32'hFFFF_FFFC;
      else if (push_e) pc_m = pc_m + 32'd4;

      if (cyc == 19) begin
        check32("s_fill_req_cycles", req_hi, DEPTH);
        check1 ("s_fill_valid", valid, 1'b1);
      end
      tick();
    end
`ifdef FETCH_STAT_EN
    check32("s_fetch_cnt", fetch_cnt, fetch_m);
    check32("s_drop_cnt",  drop_cnt,  dropc_m);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
